// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter, at most STEP positions per RUN cycle; latency 1 (amt==0) or 1+ceil(amt/STEP).
// Backpressure: ready_o low while busy; starts seen in RUN are dropped, not queued; done_o pulses once per result.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         src1_i,
  input  logic [WIDTH-1:0]         src2_i,
  input  logic [2:0]               ctrl_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH-1:0]         result_o
);

  localparam int SA_W = $clog2(WIDTH);
  localparam logic [SA_W:0] STEP_W  = (SA_W+1)'(STEP);
  localparam logic [SA_W:0] WIDTH_W = (SA_W+1)'(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  work;
  logic [WIDTH-1:0]  shifted;
  logic [1:0]        op;
  logic [SA_W-1:0]   rem;
  logic [SA_W-1:0]   load_amt;
  logic [SA_W:0]     rem_ext;
  logic [SA_W:0]     s;
  logic              accept;
  logic              last;

  // Upper src1 bits never contribute: the amount is taken modulo WIDTH.
  logic unused_src1;
  assign unused_src1 = &{1'b0, src1_i[WIDTH-1:SA_W]};

  assign load_amt = ctrl_i[2] ? src1_i[SA_W-1:0] : shamt_i;
  assign accept   = start_i & (state != RUN);
  assign rem_ext  = {1'b0, rem};
  assign s        = (rem_ext < STEP_W) ? rem_ext : STEP_W;
  assign last     = (rem_ext <= STEP_W);

  // One partial shift per cycle; SRA keeps the sign because bit WIDTH-1 never changes.
  always_comb begin
    shifted = work;
    case (op)
      OP_SLL:  shifted = work << s;
      OP_SRL:  shifted = work >> s;
      OP_SRA:  shifted = $unsigned($signed(work) >>> s);
      default: shifted = (work >> s) | (work << (WIDTH_W - s));
    endcase
  end

  always_comb begin
    state_nxt = state;
    ready_o   = (state != RUN);
    busy_o    = (state == RUN);
    done_o    = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (load_amt == '0) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      work     <= '0;
      op       <= OP_SLL;
      rem      <= '0;
      result_o <= '0;
    end else if (accept) begin
      work <= src2_i;
      op   <= ctrl_i[1:0];
      rem  <= load_amt;
      if (load_amt == '0) begin
        result_o <= src2_i;
      end
    end else if (state == RUN) begin
      work <= shifted;
      rem  <= rem - s[SA_W-1:0];
      if (last) begin
        result_o <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH=32, STEP=4): directed table, corner sequences, random ops vs model.
module tb_shift_unit_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [2:0]  ctrl_i;
  logic [4:0]  shamt_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .ctrl_i   (ctrl_i),
    .shamt_i  (shamt_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [2:0]  ctrl;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    logic [31:0] exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: the whole shift done at once from the op definition.
  function automatic logic [31:0] model_res(input logic [31:0] s1, input logic [31:0] s2,
                                            input logic [2:0] ct, input logic [4:0] sh);
    int                   a;
    logic [63:0]          dbl;
    logic signed [31:0]   sx;
    logic [31:0]          r;
    a   = ct[2] ? int'(s1 % 32) : int'(sh);
    dbl = {s2, s2};
    sx  = s2;
    case (ct[1:0])
      2'b00:   r = s2 << a;
      2'b01:   r = s2 >> a;
      2'b10:   r = sx >>> a;
      default: r = dbl[31:0] >> 0 == 0 ? 32'(dbl >> a) : 32'(dbl >> a);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_lat(input logic [31:0] s1, input logic [2:0] ct,
                                            input logic [4:0] sh);
    int a;
    a = ct[2] ? int'(s1 % 32) : int'(sh);
    return (a == 0) ? 32'd1 : 32'(1 + (a + 3) / 4);
  endfunction

  // Issue one op from IDLE, scramble inputs after accept, then check timing, result and hold.
  task automatic run_op(input logic [31:0] s1, input logic [31:0] s2, input logic [2:0] ct,
                        input logic [4:0] sh, input logic [31:0] er, input logic [31:0] el,
                        input string nm);
    int   lat;
    logic busy_ok;
    @(negedge clk_i);
    src1_i  = s1;
    src2_i  = s2;
    ctrl_i  = ct;
    shamt_i = sh;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    src1_i  = $urandom;
    src2_i  = $urandom;
    ctrl_i  = 3'($urandom);
    shamt_i = 5'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      if (c > 1) @(negedge clk_i);
      if (done_o) begin
        lat = c;
        chk({nm, " result"}, result_o, er);
        chk({nm, " busy_at_done"}, 32'(busy_o), 32'd0);
      end else if (!busy_o) begin
        busy_ok = 1'b0;
      end
    end
    chk({nm, " latency"}, 32'(lat), el);
    chk({nm, " busy_in_run"}, 32'(busy_ok), 32'd1);
    @(negedge clk_i);
    chk({nm, " done_single"}, 32'(done_o), 32'd0);
    chk({nm, " result_held"}, result_o, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          second;
    int          dones;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [2:0]  ct;
    logic [4:0]  sh;

    vecs[0] = '{32'h0000_0000, 32'h0000_0003, 3'b000, 5'd4,  32'h0000_0030, 32'd2};
    vecs[1] = '{32'h0000_0000, 32'h8000_0000, 3'b010, 5'd31, 32'hFFFF_FFFF, 32'd9};
    vecs[2] = '{32'h0000_0000, 32'h8000_0000, 3'b001, 5'd31, 32'h0000_0001, 32'd9};
    vecs[3] = '{32'hFFFF_FFE4, 32'hF000_0000, 3'b101, 5'd7,  32'h0F00_0000, 32'd2};
    vecs[4] = '{32'h0000_0000, 32'h0000_0001, 3'b011, 5'd1,  32'h8000_0000, 32'd2};
    vecs[5] = '{32'hFFFF_FFE0, 32'h1234_5678, 3'b110, 5'd9,  32'h1234_5678, 32'd1};
    vecs[6] = '{32'h0000_0000, 32'h1234_5678, 3'b011, 5'd8,  32'h7812_3456, 32'd3};
    vecs[7] = '{32'h0000_0025, 32'h0000_00FF, 3'b100, 5'd0,  32'h0000_1FE0, 32'd3};

    rst_i   = 1'b0;
    start_i = 1'b0;
    src1_i  = '0;
    src2_i  = '0;
    ctrl_i  = '0;
    shamt_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset result", result_o, 32'h0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset ready", 32'(ready_o), 32'd1);
    rst_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].src1, vecs[i].src2, vecs[i].ctrl, vecs[i].shamt,
             vecs[i].exp_res, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // start_i held with new operands during RUN is ignored; the DONE-cycle start is taken.
    @(negedge clk_i);
    src1_i  = 32'h0;
    src2_i  = 32'h8000_0000;
    ctrl_i  = 3'b010;
    shamt_i = 5'd31;
    start_i = 1'b1;
    first   = 0;
    second  = 0;
    r1      = '0;
    r2      = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        src2_i  = 32'h0000_00F0;
        ctrl_i  = 3'b000;
        shamt_i = 5'd4;
      end
      if (c == 10) start_i = 1'b0;
      if (done_o && first == 0) begin
        first = c;
        r1    = result_o;
      end else if (done_o && second == 0) begin
        second = c;
        r2     = result_o;
      end
    end
    chk("b2b first_lat", 32'(first), 32'd9);
    chk("b2b first_res", r1, 32'hFFFF_FFFF);
    chk("b2b second_lat", 32'(second), 32'd11);
    chk("b2b second_res", r2, 32'h0000_0F00);

    // Reset asserted in cycle 3 of a 31-bit SRA aborts it silently.
    @(negedge clk_i);
    src2_i  = 32'h8000_0000;
    ctrl_i  = 3'b010;
    shamt_i = 5'd31;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort ready", 32'(ready_o), 32'd1);
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort done", 32'(done_o), 32'd0);
    chk("abort result", result_o, 32'h0);
    rst_i = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    run_op(vecs[1].src1, vecs[1].src2, vecs[1].ctrl, vecs[1].shamt,
           vecs[1].exp_res, vecs[1].exp_lat, "post_abort");

    for (int i = 0; i < 40; i++) begin
      s1 = $urandom;
      s2 = $urandom;
      ct = 3'($urandom);
      sh = 5'($urandom);
      run_op(s1, s2, ct, sh, model_res(s1, s2, ct, sh), model_lat(s1, ct, sh),
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
